// File: rtl/vga_frame_reader.sv
// VGA raster generator that reads the Sobel frame buffer one pixel ahead and shows
// the captured edge magnitude as grayscale inside the top-left W x H window.
module vga_frame_reader #(
  parameter int CLK_DIV  = 4,
  parameter int READ_LAT = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sobel_ready,
  input  logic [15:0] H,
  input  logic [15:0] W,
  input  logic [7:0]  bram_data,
  output logic [15:0] VGA_Hread,
  output logic [15:0] VGA_Wread,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST  = 16'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST  = 16'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_VIS_L = 16'(H_VIS);
  localparam logic [15:0] V_VIS_L = 16'(V_VIS);
  localparam logic [15:0] HS_BEG  = 16'(H_VIS + H_FP);
  localparam logic [15:0] HS_END  = 16'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_BEG  = 16'(V_VIS + V_FP);
  localparam logic [15:0] VS_END  = 16'(V_VIS + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pos_t;

  typedef enum logic [1:0] {WAIT_READY, WAIT_FRAME, DISPLAY} state_t;

  function automatic pos_t step(input pos_t p);
    pos_t n;
    n.x = (p.x == H_LAST) ? 16'd0 : p.x + 16'd1;
    n.y = (p.x != H_LAST) ? p.y : (p.y == V_LAST) ? 16'd0 : p.y + 16'd1;
    return n;
  endfunction

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [15:0]        h_cnt, v_cnt;
  logic               pix_tick;
  pos_t               cur, nxt, pf;
  logic [15:0]        weff, heff;
  logic               pf_in, nxt_vis, nxt_home, show;
  logic               pf_img;
  logic [READ_LAT-1:0] vld_pipe;
  logic [7:0]         cap_reg;
  logic               cap_img;
  logic               cap_lsb_unused;

  // Only the high nibble reaches the 12-bit DAC.
  assign cap_lsb_unused = ^cap_reg[3:0];

  always_comb begin
    pix_tick = (div_cnt == DIV_LAST);
    weff     = (W > H_VIS_L) ? H_VIS_L : W;
    heff     = (H > V_VIS_L) ? V_VIS_L : H;
    cur.x    = h_cnt;
    cur.y    = v_cnt;
    nxt      = step(cur);
    pf       = step(nxt);
    pf_in    = (pf.x < weff) && (pf.y < heff);
    nxt_vis  = (nxt.x < H_VIS_L) && (nxt.y < V_VIS_L);
    nxt_home = (nxt.x == 16'd0) && (nxt.y == 16'd0);
    // WAIT_FRAME arms on the same tick that enters (0,0), so that pixel is shown.
    show     = sobel_ready && nxt_vis && cap_img &&
               ((state == DISPLAY) || (state == WAIT_FRAME && nxt_home));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_READY;
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      VGA_Wread   <= '0;
      VGA_Hread   <= '0;
      pf_img      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      div_cnt     <= pix_tick ? '0 : div_cnt + DIV_W'(1);
      frame_start <= 1'b0;
      case (state)
        WAIT_READY: if (sobel_ready) state <= WAIT_FRAME;
        WAIT_FRAME: if (!sobel_ready) state <= WAIT_READY;
                    else if (pix_tick && nxt_home) state <= DISPLAY;
        DISPLAY:    if (!sobel_ready) state <= WAIT_READY;
        default:    state <= WAIT_READY;
      endcase
      if (pix_tick) begin
        h_cnt       <= nxt.x;
        v_cnt       <= nxt.y;
        hsync       <= !((nxt.x >= HS_BEG) && (nxt.x <= HS_END));
        vsync       <= !((nxt.y >= VS_BEG) && (nxt.y <= VS_END));
        frame_start <= nxt_home;
        // Address the pixel after the one being entered; park at 0,0 outside the image.
        VGA_Wread   <= pf_in ? pf.x : 16'd0;
        VGA_Hread   <= pf_in ? pf.y : 16'd0;
        pf_img      <= pf_in;
        vga_r       <= show ? cap_reg[7:4] : 4'd0;
        vga_g       <= show ? cap_reg[7:4] : 4'd0;
        vga_b       <= show ? cap_reg[7:4] : 4'd0;
      end
    end
  end

  // vld_pipe[i] marks the clock i+1 edges after a pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      cap_reg  <= '0;
      cap_img  <= 1'b0;
    end else begin
      vld_pipe[0] <= pix_tick;
      for (int i = 1; i < READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (vld_pipe[READ_LAT-1]) begin
        cap_reg <= bram_data;
        cap_img <= pf_img;
      end
    end
  end

endmodule
